// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory, with lock and bounded hold.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic              lock_a,
  input  logic              lock_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d, hold_nxt;
  logic       last_gnt_q, last_gnt_d;   // 1 = B
  logic       force_a_q, force_a_d;
  logic       force_b_q, force_b_d;
  logic       rdy_q;
  logic       rvalid_a_q, rvalid_b_q;

  // rdy_q keeps grants off until the first edge after reset release.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rdy_q) begin
      case (state_q)
        IDLE: begin
          if (req_a && req_b) begin
            if (force_a_q) begin
              gnt_a = 1'b1;
            end else if (force_b_q) begin
              gnt_b = 1'b1;
            end else begin
`ifdef DMEM_ARB_RR_EN
              gnt_a = last_gnt_q;
              gnt_b = ~last_gnt_q;
`else
              gnt_a = 1'b1;
`endif
            end
          end else begin
            gnt_a = req_a;
            gnt_b = req_b;
          end
        end
        OWN_A:   gnt_a = req_a;
        OWN_B:   gnt_b = req_b;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    last_gnt_d = last_gnt_q;
    force_a_d  = force_a_q;
    force_b_d  = force_b_q;
    hold_nxt   = hold_q;
    if (gnt_a) begin
      last_gnt_d = 1'b0;
    end else if (gnt_b) begin
      last_gnt_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        force_a_d = 1'b0;
        force_b_d = 1'b0;
        hold_d    = '0;
        if (gnt_a && lock_a) begin
          state_d = OWN_A;
        end else if (gnt_b && lock_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (req_b && hold_q != LOCK_LIM) hold_nxt = hold_q + 8'd1;
        if (!req_a || !lock_a || hold_nxt == LOCK_LIM) begin
          state_d   = IDLE;
          hold_d    = '0;
          force_b_d = (hold_nxt == LOCK_LIM);
        end else begin
          hold_d = hold_nxt;
        end
      end
      OWN_B: begin
        if (req_a && hold_q != LOCK_LIM) hold_nxt = hold_q + 8'd1;
        if (!req_b || !lock_b || hold_nxt == LOCK_LIM) begin
          state_d   = IDLE;
          hold_d    = '0;
          force_a_d = (hold_nxt == LOCK_LIM);
        end else begin
          hold_d = hold_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      last_gnt_q <= 1'b1;
      force_a_q  <= 1'b0;
      force_b_q  <= 1'b0;
      rdy_q      <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      last_gnt_q <= last_gnt_d;
      force_a_q  <= force_a_d;
      force_b_q  <= force_b_d;
      rdy_q      <= 1'b1;
      rvalid_a_q <= gnt_a & ~we_a;
      rvalid_b_q <= gnt_b & ~we_b;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_a) begin
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
  end

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = rvalid_a_q ? mem_rdata : '0;
  assign rdata_b  = rvalid_b_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 synchronous memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        exp_a;

  dmem_arbiter #(.LOCK_MAX(16), .ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .lock_a(lock_a), .lock_b(lock_b), .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Read-before-write memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_rdata = '0;
    rst_n = 1'b0;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    lock_a = 1'b0; lock_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
    check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
    check("rst_rdata_a", rdata_a, 32'd0);
    check("rst_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_no_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    @(negedge clk); #1;
    check("first_contention", {30'd0, gnt_a, gnt_b}, 32'd2);

    // Uncontended write then read by A.
    @(negedge clk);
    req_b = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'h005; wdata_a = 32'hDEADBEEF;
    #1;
    check("wr_gnt_a", 32'(gnt_a), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h005);
    check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    we_a = 1'b0;
    #1;
    check("rd_gnt_a", 32'(gnt_a), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    req_a = 1'b0;
    #1;
    check("rd_rvalid_a", 32'(rvalid_a), 32'd1);
    check("rd_rdata_a", rdata_a, 32'hDEADBEEF);
    check("idle_mem_addr", 32'(mem_addr), 32'd0);

    // A writes N, B reads N on the next cycle.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'h02A; wdata_a = 32'h12345678;
    #1;
    check("raw_rvalid_a_drop", 32'(rvalid_a), 32'd0);
    @(negedge clk);
    req_a = 1'b0; we_a = 1'b0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 10'h02A;
    #1;
    check("raw_gnt_b", 32'(gnt_b), 32'd1);
    @(negedge clk);
    req_b = 1'b0;
    #1;
    check("raw_rvalid_b", 32'(rvalid_b), 32'd1);
    check("raw_rdata_b", rdata_b, 32'h12345678);

    // Continuous contention; last grant was B.
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; addr_a = 10'h005; addr_b = 10'h02A;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      #1;
      check($sformatf("cont_gnt_%0d", i), {30'd0, gnt_a, gnt_b}, {30'd0, exp_a, ~exp_a});
      @(negedge clk);
    end
    req_a = 1'b0; req_b = 1'b0;

    // Lock by B for 5 transfers, unlock on the 6th, then check IDLE.
    @(negedge clk);
    req_b = 1'b1; lock_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("lock_gnt_b_%0d", i), 32'(gnt_b), 32'd1);
      @(negedge clk);
    end
    lock_b = 1'b0;
    #1;
    check("unlock_gnt_b", 32'(gnt_b), 32'd1);
    @(negedge clk);
    req_a = 1'b1;
    #1;
    check("lock_exit_idle", {30'd0, gnt_a, gnt_b}, 32'd2);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;

    // Force release: B locks, A waits LOCK_MAX cycles.
    @(negedge clk);
    req_b = 1'b1; lock_b = 1'b1;
    #1;
    check("force_entry_gnt_b", 32'(gnt_b), 32'd1);
    @(negedge clk);
    req_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("force_wait_%0d", i), {30'd0, gnt_a, gnt_b}, 32'd1);
      @(negedge clk);
    end
    #1;
    check("force_release", {30'd0, gnt_a, gnt_b}, 32'd2);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; lock_b = 1'b0;

    // Reset right after a B read grant.
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b0; addr_b = 10'h005;
    #1;
    check("rstrd_gnt_b", 32'(gnt_b), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; req_b = 1'b0;
    #1;
    check("rstrd_rvalid_b", 32'(rvalid_b), 32'd0);
    check("rstrd_rdata_b", rdata_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rstrd_after_rvalid_b", 32'(rvalid_b), 32'd0);
    check("rstrd_after_rdata_b", rdata_b, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
